demux1_2_flop: RTL and testbench
================================

# demux1_2_flop

Registered 1-to-2 demultiplexer for DATA_W-bit words, the counterpart of the 2:1 registered multiplexer in the mux test environment. It accepts one word per cycle on a valid/ready input port and routes it, selected by `selector`, into one of two independent one-entry output registers, each with its own valid/ready handshake. Its outputs feed the mux data inputs and tester checkers, so mux and demux can be chained back-to-back in a loopback bench.

## Interface
- `DATA_W`, 2: width of data words.
- `CNT_W`, 7: width of the per-output accepted-word counters; used only when counting is compiled in.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  input word present.
- `data_in`  in  DATA_W  input word.
- `selector`  in  1  destination: 0 → output 0, 1 → output 1; sampled with `valid_in`.
- `ready_in`  out  1  block accepts the input word this cycle.
- `valid_out0` / `valid_out1`  out  1  output register n holds a word.
- `data_out0` / `data_out1`  out  DATA_W  output register n contents.
- `ready0` / `ready1`  in  1  downstream n takes the word this cycle.
- `cnt_out0` / `cnt_out1`  out  CNT_W  accepted-word counters; present only with `DEMUX_WORD_CNT_EN`.

## Operation
- Input handshake: transfer when `valid_in && ready_in`.
- Output handshake n: transfer when `valid_outn && readyn`.
- `ready_in` is combinational:
  - `selector=0`: `!valid_out0 || ready0`.
  - `selector=1`: `!valid_out1 || ready1`.
  - It never depends on the non-selected output.
- Each output register is a two-state FSM.
  - EMPTY → FULL on an input transfer targeting it.
  - FULL → EMPTY on an output transfer with no new input transfer targeting it.
  - FULL → FULL on a simultaneous output transfer and input transfer targeting it: the new word replaces the old one, with no bubble.
- `data_outn` loads only on an input transfer targeting n.
  - It holds its last value while EMPTY.
  - It never takes the other output's data.
- The non-selected output is untouched in every cycle.
- `valid_in` without `ready_in`: nothing is captured. Upstream must hold `valid_in`, `data_in` and `selector` stable until acceptance.
- `ready_in` may be high with `valid_in` low; no effect.

## Timing
- Latency: word accepted at edge k → visible on `data_outn` with `valid_outn=1` right after edge k.
- Throughput: one word per cycle sustained when the target output drains every cycle (`readyn=1`).
- Both outputs may drain in the same cycle as an input transfer.
- Reset values: `valid_out0=valid_out1=0`, `data_out0=data_out1=0`, counters 0.
- `ready_in` is 1 in the first cycle after reset.
- Reset mid-operation: pending words are discarded, with no output transfer that cycle. Input is ignored while `reset=1`.

## Configuration
- `DEMUX_WORD_CNT_EN` defined:
  - `cnt_out0`/`cnt_out1` exist.
  - Each increments by 1 on every input transfer routed to its output.
  - Each saturates at 2^CNT_W−1 and does not wrap.
  - Both are cleared by `reset`.
- `DEMUX_WORD_CNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package `demux_pkg`:
  - Default `DATA_W`/`CNT_W` constants.
  - Output-FSM state encoding: EMPTY=1'b0, FULL=1'b1.
  - Selector constants SEL_OUT0=1'b0, SEL_OUT1=1'b1.
- Sub-module `demux_out_reg`: one output register with its FSM, data hold and optional counter. It is instantiated twice; the top contains only routing and the `ready_in` logic.

## Test plan
- Reset, `valid_in=0` → all outputs 0, `ready_in=1`. With the macro defined, counters = 0.
- `ready0=ready1=1`, send 2'b01 sel 0 then 2'b10 sel 1 on consecutive cycles → `data_out0=01` with `valid_out0=1` one cycle after the first; `data_out1=10` with `valid_out1=1` one cycle after the second; `data_out0` stays 01.
- `ready0=0`, send 2'b11 sel 0, then 2'b00 sel 0 → second word stalls with `ready_in=0`. Raise `ready0` → 11 drains, 00 loaded same edge, `valid_out0` stays 1.
- Output 0 FULL and stalled, send 2'b10 sel 1 → `ready_in=1`, `data_out1=10` next cycle; output 0 unchanged.
- With macro: 130 words to output 0 at `ready0=1` → `cnt_out0=127` (saturated), `cnt_out1=0`.
- Both outputs FULL, assert `reset` for one cycle → `valid_out0=valid_out1=0`, data 0, counters 0; no output transfer observed.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and encodings for the registered 1-to-2 demultiplexer.
// Also used by the optional DEMUX_WORD_CNT_EN accepted-word counters.
package demux_pkg;

  localparam int DEMUX_DATA_W = 2;
  localparam int DEMUX_CNT_W  = 7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry output register of the demux: EMPTY/FULL state, held data word
// and, with DEMUX_WORD_CNT_EN defined, a saturating accepted-word counter.
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int CNT_W  = DEMUX_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic              slot_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
`ifdef DEMUX_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_out
`endif
);

  if (DATA_W < 1 || CNT_W < 1 || CNT_W > 31) begin : g_bad_param
    $error("demux_out_reg: unsupported DATA_W/CNT_W");
  end

  out_state_e        state;
  logic [DATA_W-1:0] data_q;

  // Output register stage: load always wins over drain, so a word arriving
  // while the old one leaves replaces it with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      data_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (load) begin
            state  <= FULL;
            data_q <= data_in;
          end
        end
        FULL: begin
          if (load) begin
            data_q <= data_in;
          end else if (ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Reset masks valid so a pending word never appears to transfer while it
  // is being discarded.
  assign valid_out  = (state == FULL) && !reset;
  assign data_out   = data_q;
  assign slot_ready = !valid_out || ready;

`ifdef DEMUX_WORD_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign cnt_out = cnt_q;
`endif

endmodule

// File: rtl/demux1_2_flop.sv
// Registered 1-to-2 demultiplexer with valid/ready on the input and on each
// output. Define DEMUX_WORD_CNT_EN to add per-output accepted-word counters.
module demux1_2_flop
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int CNT_W  = DEMUX_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              selector,
  output logic              ready_in,
  output logic              valid_out0,
  output logic [DATA_W-1:0] data_out0,
  input  logic              ready0,
  output logic              valid_out1,
  output logic [DATA_W-1:0] data_out1,
  input  logic              ready1
`ifdef DEMUX_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_out0,
  output logic [CNT_W-1:0]  cnt_out1
`endif
);

  logic slot_ready0;
  logic slot_ready1;
  logic xfer_in;
  logic load0;
  logic load1;

  // Only the selected output decides acceptance; the other one is never
  // consulted, so a stalled output cannot block traffic to its sibling.
  assign ready_in = (selector == SEL_OUT1) ? slot_ready1 : slot_ready0;
  assign xfer_in  = valid_in && ready_in && !reset;
  assign load0    = xfer_in && (selector == SEL_OUT0);
  assign load1    = xfer_in && (selector == SEL_OUT1);

  demux_out_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_out0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .data_in   (data_in),
    .ready     (ready0),
    .slot_ready(slot_ready0),
    .valid_out (valid_out0),
    .data_out  (data_out0)
`ifdef DEMUX_WORD_CNT_EN
    ,
    .cnt_out   (cnt_out0)
`endif
  );

  demux_out_reg #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_out1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .data_in   (data_in),
    .ready     (ready1),
    .slot_ready(slot_ready1),
    .valid_out (valid_out1),
    .data_out  (data_out1)
`ifdef DEMUX_WORD_CNT_EN
    ,
    .cnt_out   (cnt_out1)
`endif
  );

endmodule

// File: tb/tb_demux1_2_flop.sv
// Self-checking bench for demux1_2_flop: directed scenarios plus randomized
// traffic compared each cycle against a slot-level model of the two outputs.
module tb_demux1_2_flop;

  localparam int DW   = 2;
  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          selector;
  logic          ready_in;
  logic          valid_out0;
  logic [DW-1:0] data_out0;
  logic          ready0;
  logic          valid_out1;
  logic [DW-1:0] data_out1;
  logic          ready1;
`ifdef DEMUX_WORD_CNT_EN
  logic [CW-1:0] cnt_out0;
  logic [CW-1:0] cnt_out1;
`endif

  always #5 clk = ~clk;

  demux1_2_flop #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .selector  (selector),
    .ready_in  (ready_in),
    .valid_out0(valid_out0),
    .data_out0 (data_out0),
    .ready0    (ready0),
    .valid_out1(valid_out1),
    .data_out1 (data_out1),
    .ready1    (ready1)
`ifdef DEMUX_WORD_CNT_EN
    ,
    .cnt_out0  (cnt_out0),
    .cnt_out1  (cnt_out1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each output is a slot that is either occupied or not, remembers
  // the last word written into it, and counts words written (saturating).
  bit            m_full [2];
  logic [DW-1:0] m_word [2];
  int            m_cnt  [2];
  logic          m_s;
  bit            m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_full = '{0, 0};
      m_word = '{'0, '0};
      m_cnt  = '{0, 0};
    end else begin
      m_s   = selector;
      m_acc = valid_in && (!m_full[m_s] || (m_s ? ready1 : ready0));
      if (m_full[0] && ready0) m_full[0] = 0;
      if (m_full[1] && ready1) m_full[1] = 0;
      if (m_acc) begin
        m_full[m_s] = 1;
        m_word[m_s] = data_in;
        if (m_cnt[m_s] < CMAX) m_cnt[m_s]++;
      end
    end
  end

  logic e_v0, e_v1, e_rdy;

  always @(negedge clk) begin
    if (check_en) begin
      e_v0  = m_full[0] && !reset;
      e_v1  = m_full[1] && !reset;
      e_rdy = selector ? (!e_v1 || ready1) : (!e_v0 || ready0);
      chk("valid_out0", 32'(valid_out0), 32'(e_v0));
      chk("valid_out1", 32'(valid_out1), 32'(e_v1));
      chk("data_out0",  32'(data_out0),  32'(m_word[0]));
      chk("data_out1",  32'(data_out1),  32'(m_word[1]));
      chk("ready_in",   32'(ready_in),   32'(e_rdy));
`ifdef DEMUX_WORD_CNT_EN
      chk("cnt_out0",   32'(cnt_out0),   m_cnt[0]);
      chk("cnt_out1",   32'(cnt_out1),   m_cnt[1]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  bit acc;
  bit rst_prev;

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    selector = 1'b0;
    ready0   = 1'b1;
    ready1   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset    = 1'b0;
    check_en = 1'b1;
    cyc();
    #1;
    chk("rst_valid0", 32'(valid_out0), 32'd0);
    chk("rst_valid1", 32'(valid_out1), 32'd0);
    chk("rst_data0",  32'(data_out0),  32'd0);
    chk("rst_data1",  32'(data_out1),  32'd0);
    chk("rst_ready",  32'(ready_in),   32'd1);
`ifdef DEMUX_WORD_CNT_EN
    chk("rst_cnt0",   32'(cnt_out0),   32'd0);
    chk("rst_cnt1",   32'(cnt_out1),   32'd0);
`endif

    // Back-to-back words to alternate outputs.
    valid_in = 1'b1; data_in = 2'b01; selector = 1'b0;
    cyc();
    data_in = 2'b10; selector = 1'b1;
    #1;
    chk("seq_valid0", 32'(valid_out0), 32'd1);
    chk("seq_data0",  32'(data_out0),  32'h1);
    cyc();
    valid_in = 1'b0;
    #1;
    chk("seq_valid1",  32'(valid_out1), 32'd1);
    chk("seq_data1",   32'(data_out1),  32'h2);
    chk("seq_hold0",   32'(data_out0),  32'h1);
    chk("seq_drained0", 32'(valid_out0), 32'd0);

    // Stall on output 0, then drain and reload on the same edge.
    ready0 = 1'b0;
    valid_in = 1'b1; data_in = 2'b11; selector = 1'b0;
    cyc();
    data_in = 2'b00;
    #1;
    chk("stall_ready", 32'(ready_in),   32'd0);
    chk("stall_v0",    32'(valid_out0), 32'd1);
    chk("stall_d0",    32'(data_out0),  32'h3);
    cyc();
    #1;
    chk("stall_d0_hold", 32'(data_out0), 32'h3);
    ready0 = 1'b1;
    #1;
    chk("unstall_ready", 32'(ready_in), 32'd1);
    cyc();
    valid_in = 1'b0; ready0 = 1'b0;
    #1;
    chk("reload_v0", 32'(valid_out0), 32'd1);
    chk("reload_d0", 32'(data_out0),  32'h0);

    // Output 0 stalled full must not block output 1.
    ready1 = 1'b0;
    valid_in = 1'b1; data_in = 2'b10; selector = 1'b1;
    #1;
    chk("bypass_ready", 32'(ready_in), 32'd1);
    cyc();
    valid_in = 1'b0;
    #1;
    chk("bypass_v1", 32'(valid_out1), 32'd1);
    chk("bypass_d1", 32'(data_out1),  32'h2);
    chk("bypass_v0", 32'(valid_out0), 32'd1);
    chk("bypass_d0", 32'(data_out0),  32'h0);
`ifdef DEMUX_WORD_CNT_EN
    chk("pre_rst_cnt0", 32'(cnt_out0), 32'd3);
    chk("pre_rst_cnt1", 32'(cnt_out1), 32'd2);
`endif

    // Reset with both outputs full: nothing may appear to transfer.
    reset = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    #1;
    chk("inrst_v0", 32'(valid_out0), 32'd0);
    chk("inrst_v1", 32'(valid_out1), 32'd0);
    cyc();
    reset = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    #1;
    chk("postrst_v0", 32'(valid_out0), 32'd0);
    chk("postrst_v1", 32'(valid_out1), 32'd0);
    chk("postrst_d0", 32'(data_out0),  32'd0);
    chk("postrst_d1", 32'(data_out1),  32'd0);
`ifdef DEMUX_WORD_CNT_EN
    chk("postrst_cnt0", 32'(cnt_out0), 32'd0);
    chk("postrst_cnt1", 32'(cnt_out1), 32'd0);

    // Counter saturation.
    ready0 = 1'b1; valid_in = 1'b1; selector = 1'b0;
    repeat (130) begin
      data_in = DW'($urandom);
      cyc();
    end
    valid_in = 1'b0;
    #1;
    chk("sat_cnt0", 32'(cnt_out0), 32'd127);
    chk("sat_cnt1", 32'(cnt_out1), 32'd0);
`endif

    // Randomized traffic with held-until-accepted upstream.
    rst_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc      = valid_in && ready_in && !reset;
      rst_prev = reset;
      @(posedge clk);
      #2;
      reset  = ($urandom_range(0, 99) == 0);
      ready0 = ($urandom_range(0, 3) != 0);
      ready1 = ($urandom_range(0, 2) != 0);
      if (!valid_in || acc || rst_prev) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = DW'($urandom);
        selector = 1'($urandom);
      end
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
